// File: rtl/uart_rx_fifo.sv
// Receive character buffer behind the UART receiver.
// Show-ahead FIFO with rx_done edge capture, overrun/underflow status and RTS hysteresis.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int RTS_HI = 12,
    parameter int RTS_LO = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_parity_error,
    input  logic                     rx_done,
    output logic                     host_read_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    input  logic                     flush,
    input  logic                     overrun_clr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     underflow,
    output logic                     rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LVL_HI = PW'(RTS_HI);
    localparam logic [PW-1:0] LVL_LO = PW'(RTS_LO);

    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_d;
    logic          rx_done_q;
    logic          host_read_data_q, host_read_data_d;
    logic          overrun_q, overrun_d;
    logic          underflow_q, underflow_d;
    logic          rts_n_q, rts_n_d;
    logic          push, pop, wr_en;

    // Occupancy flags and edge-detected push / qualified pop.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level = wr_ptr_q - rd_ptr_q;
        push  = rx_done && !rx_done_q;
        pop   = rd_en && !empty && !flush;
        // A pop in the same cycle frees the slot the push needs.
        wr_en = push && !flush && (!full || pop);
    end

    // Next-state for pointers, status flags and flow control.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        host_read_data_d = push;
        underflow_d      = rd_en && empty;
        overrun_d        = overrun_q;
        rts_n_d          = rts_n_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !flush && full && !pop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        level_d = wr_ptr_d - rd_ptr_d;
        if (level_d >= LVL_HI) begin
            rts_n_d = 1'b1;
        end else if (level_d <= LVL_LO) begin
            rts_n_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            rx_done_q        <= 1'b0;
            host_read_data_q <= 1'b0;
            overrun_q        <= 1'b0;
            underflow_q      <= 1'b0;
            rts_n_q          <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            rx_done_q        <= rx_done;
            host_read_data_q <= host_read_data_d;
            overrun_q        <= overrun_d;
            underflow_q      <= underflow_d;
            rts_n_q          <= rts_n_d;
        end
    end

    // Character storage; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {rx_parity_error, rx_data};
    end

    // Show-ahead head entry, forced to zero when empty.
    always_comb begin
        rd_data       = 8'h00;
        rd_parity_err = 1'b0;
        if (!empty) begin
            rd_data       = mem[rd_ptr_q[AW-1:0]][7:0];
            rd_parity_err = mem[rd_ptr_q[AW-1:0]][8];
        end
        host_read_data = host_read_data_q;
        overrun        = overrun_q;
        underflow      = underflow_q;
        rts_n          = rts_n_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// A queue-based reference model tracks contents and status; a monitor checks every read.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int HI    = 12;
    localparam int LO    = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_parity_error = 1'b0;
    logic       rx_done = 1'b0;
    logic       host_read_data;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       flush = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       empty, full, overrun, underflow, rts_n;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0] exp_q[$];
    int mcount = 0;
    bit m_prev = 0, m_ov = 0, m_uf = 0, m_hrd = 0, m_rts = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .RTS_HI(HI), .RTS_LO(LO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_parity_error(rx_parity_error),
        .rx_done(rx_done), .host_read_data(host_read_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
        .flush(flush), .overrun_clr(overrun_clr),
        .empty(empty), .full(full), .level(level),
        .overrun(overrun), .underflow(underflow), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: characters are queued on each rx_done rise.
    always @(posedge clk or negedge reset_n) begin
        bit push, pop, ovset;
        if (!reset_n) begin
            mcount = 0; m_prev = 0; m_ov = 0; m_uf = 0; m_hrd = 0; m_rts = 0;
            exp_q.delete();
        end else begin
            push   = rx_done && !m_prev;
            m_prev = rx_done;
            pop    = rd_en && mcount > 0 && !flush;
            m_hrd  = push;
            m_uf   = rd_en && mcount == 0;
            ovset  = push && !flush && mcount == DEPTH && !pop;
            if (flush) begin
                mcount = 0;
                exp_q.delete();
            end else begin
                if (pop) mcount--;
                if (push && mcount < DEPTH) begin
                    mcount++;
                    exp_q.push_back({rx_parity_error, rx_data});
                end
            end
            if (ovset) m_ov = 1;
            else if (overrun_clr) m_ov = 0;
            if (mcount >= HI) m_rts = 1;
            else if (mcount <= LO) m_rts = 0;
        end
    end

    // Status comparison against the model every cycle.
    always @(negedge clk) begin
        chk("level", int'(level), mcount);
        chk("empty", int'(empty), int'(mcount == 0));
        chk("full", int'(full), int'(mcount == DEPTH));
        chk("overrun", int'(overrun), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_uf));
        chk("host_read_data", int'(host_read_data), int'(m_hrd));
        chk("rts_n", int'(rts_n), int'(m_rts));
        if (mcount == 0) begin
            chk("rd_data_empty", int'(rd_data), 0);
            chk("rd_par_empty", int'(rd_parity_err), 0);
        end
    end

    // Read monitor: whenever the DUT presents a pop, check the head entry.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset_n && rd_en && !flush && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got %0h expected none", rd_data);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e[7:0]));
                chk("rd_parity_err", int'(rd_parity_err), int'(e[8]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic p, input int hold);
        rx_data = d;
        rx_parity_error = p;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        int hrd_cnt;
        repeat (3) tick();
        chk("reset_empty", int'(empty), 1);
        chk("reset_rts", int'(rts_n), 0);
        reset_n = 1'b1;
        tick();

        // Single character with a long rx_done level
        hrd_cnt = 0;
        rx_data = 8'hA5;
        rx_parity_error = 1'b0;
        rx_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (host_read_data) hrd_cnt++;
        end
        rx_done = 1'b0;
        tick();
        chk("hrd_once", hrd_cnt, 1);
        chk("single_data", int'(rd_data), 8'hA5);
        pop_n(1);
        chk("single_empty", int'(empty), 1);

        // Fill, overrun, drain in order, clear
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
        send(8'h55, 1'b0, 2);
        chk("fill_full", int'(full), 1);
        chk("fill_overrun", int'(overrun), 1);
        pop_n(16);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tick();
        chk("ovr_cleared", int'(overrun), 0);

        // RTS hysteresis
        for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0, 1);
        chk("rts_set", int'(rts_n), 1);
        pop_n(3);
        chk("rts_hold", int'(rts_n), 1);
        pop_n(1);
        chk("rts_clr", int'(rts_n), 0);
        pop_n(8);

        // Push coincident with pop at full
        for (int i = 0; i < 16; i++) send(8'($urandom), 1'($urandom), 1);
        rx_data = 8'hC3;
        rx_parity_error = 1'b1;
        rx_done = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        rx_done = 1'b0;
        tick();
        chk("simul_full_level", int'(level), 16);
        pop_n(16);

        // Push coincident with rd_en when empty
        rx_data = 8'h3C;
        rx_done = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        rx_done = 1'b0;
        chk("simul_empty_uf", int'(underflow), 1);
        tick();
        pop_n(1);

        // Wrap-around with alternating parity and random pops
        for (int i = 0; i < 40; i++) begin
            rx_data = 8'($urandom);
            rx_parity_error = 1'(i & 1);
            rx_done = 1'b1;
            rd_en = ($urandom % 4) != 0;
            tick();
            rx_done = 1'b0;
            rd_en = 1'($urandom);
            tick();
        end
        rd_en = 1'b0;
        pop_n(16);

        // Flush with coincident push while overrun is set
        for (int i = 0; i < 17; i++) send(8'(i + 8'h40), 1'b0, 1);
        pop_n(11);
        chk("pre_flush_level", int'(level), 5);
        rx_done = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rx_done = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_hrd", int'(host_read_data), 1);
        chk("flush_ovr", int'(overrun), 1);
        tick();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_level", int'(level), 0);
        chk("areset_rts", int'(rts_n), 0);
        chk("areset_ovr", int'(overrun), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rx_data = 8'($urandom);
            rx_parity_error = 1'($urandom);
            rx_done = ($urandom % 3) == 0;
            rd_en = (i < 300) ? (($urandom % 6) == 0) : (($urandom % 2) == 0);
            flush = ($urandom % 60) == 0;
            overrun_clr = ($urandom % 25) == 0;
            tick();
        end
        rx_done = 1'b0;
        flush = 1'b0;
        overrun_clr = 1'b0;
        rd_en = 1'b0;
        tick();
        pop_n(16);
        chk("final_empty", int'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Captures each completed character (data byte plus parity-error tag) on the rising edge of the receiver's rx_done level and stores it in a show-ahead FIFO. The APB register block reads characters from this FIFO. The block drives the receiver's host_read_data acknowledge and generates hysteretic RTS flow control, overrun and underflow status.

Parameters:
DEPTH, 16, number of entries; must be a power of two, range 4 to 256.
RTS_HI, 12, level at or above which rts_n is driven 1 (stop the sender).
RTS_LO, 8, level at or below which rts_n returns to 0; RTS_LO < RTS_HI <= DEPTH.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
rx_data  in  8  received byte from the receiver, already right-aligned.
rx_parity_error  in  1  parity error flag for rx_data.
rx_done  in  1  receiver character-complete level; may stay high for many cycles.
host_read_data  out  1  one-cycle acknowledge to the receiver that the character was taken.
rd_en  in  1  pop request from the APB side; one pulse pops one entry.
rd_data  out  8  byte at the FIFO head (show-ahead); 0 when empty.
rd_parity_err  out  1  parity tag of the head entry; 0 when empty.
flush  in  1  synchronous clear of the FIFO contents.
overrun_clr  in  1  clears the overrun sticky flag.
empty  out  1  level == 0.
full  out  1  level == DEPTH.
level  out  $clog2(DEPTH)+1  current occupancy.
overrun  out  1  sticky: a character arrived while the FIFO was full.
underflow  out  1  one-cycle pulse: rd_en was asserted while empty.
rts_n  out  1  flow control to the peer; 0 means ready to receive.

Behaviour:
- Reset values: empty=1, full=0, level=0, overrun=0, underflow=0, host_read_data=0, rd_data=0, rd_parity_err=0, rts_n=0. Pointers=0 and the rx_done edge register=0.
- Push event: rx_done=1 and registered rx_done_q=0 (rising edge). rx_data and rx_parity_error are sampled in that same cycle.
- A push while not full writes the 9-bit entry {parity, data} at wr_ptr, increments wr_ptr, and raises level in the next cycle.
- host_read_data pulses 1 in the cycle after any push event, whether the push was accepted or dropped, so the receiver always releases rx_done.
- A push while full, without a pop in the same cycle, drops the character and sets overrun in the next cycle. FIFO contents are untouched.
- Pop event: rd_en=1 while not empty. Increments rd_ptr; the new head is visible on rd_data in the next cycle.
- rd_en while empty is ignored and pulses underflow for one cycle.
- Simultaneous push and pop:
  - When not empty, both take effect and level is unchanged.
  - When full, the pop frees a slot, the push is accepted, and overrun is not set.
  - When empty, only the push takes effect and underflow pulses.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - empty when the pointers are fully equal.
  - full when the MSBs differ and the remaining bits are equal.
  - level = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- rd_data and rd_parity_err are taken combinationally from the memory at rd_ptr, gated to 0 when empty.
- flush has priority over push and pop in the same cycle.
  - Pointers go to 0.
  - A coincident push is discarded, but host_read_data still pulses.
  - overrun is unaffected.
- overrun_clr clears overrun. A set and a clear in the same cycle leave overrun=1.
- rts_n is registered and evaluated on the next-state level:
  - It goes to 1 when the next level >= RTS_HI.
  - It goes to 0 when the next level <= RTS_LO.
  - Between the two thresholds it holds its value.
  - A flush therefore drops rts_n to 0 in the following cycle.
- Reset mid-operation immediately returns all state to the reset values. Memory contents are not cleared.

Test Plan:
- Single character: push 0xA5 with parity 0 and rx_done held high for 20 cycles.
  - host_read_data pulses once, one cycle after the edge.
  - level=1, rd_data=0xA5, empty=0.
  - rd_en pulse: empty=1, rd_data=0.
- Fill and overrun: push 0x00 through 0x0F (16 characters), then push 0x55.
  - full=1 and overrun=1; level stays 16.
  - Reading all 16 returns 0x00 through 0x0F in order, with no 0x55.
  - overrun_clr gives overrun=0.
- RTS hysteresis with RTS_HI=12 and RTS_LO=8:
  - Push 11 characters: rts_n=0. The 12th push sets rts_n=1.
  - Pop down to level 9: rts_n stays 1. The pop to level 8 sets rts_n=0.
- Simultaneous events:
  - At level 16, a push edge coincident with rd_en: level stays 16, overrun stays 0, and the new byte reads out last.
  - At level 0, a push coincident with rd_en: level=1 and underflow pulses.
- Parity tagging and wrap-around: push 40 characters with alternating parity_error while popping continuously. Every byte and parity tag matches, in order, across pointer wraps.
- Flush and reset mid-operation:
  - At level 5, flush with a coincident push edge: level=0 next cycle, host_read_data pulses, and overrun is retained.
  - Asserting reset_n low at level 7 gives level=0, rts_n=0, and overrun=0 asynchronously.
